// File: rtl/lb_arbiter_pkg.sv
// Shared types and constants for the two-master local-bus arbiter.
package lb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_e;

    localparam int unsigned NUM_MASTERS = 2;

    localparam logic [NUM_MASTERS-1:0] GNT_NONE = 2'b00;
    localparam logic [NUM_MASTERS-1:0] GNT_M0   = 2'b01;
    localparam logic [NUM_MASTERS-1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/lb_arbiter_picker.sv
// Combinational winner select. LB_ARBITER_RR_EN selects round-robin tie-break;
// otherwise master 0 wins every tie and no pointer input exists.
module lb_arbiter_picker
    import lb_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
`ifdef LB_ARBITER_RR_EN
    input  logic                   last_gnt,
`endif
    output logic [NUM_MASTERS-1:0] gnt_c
);

    always_comb begin
        gnt_c = GNT_NONE;
        if (req == 2'b11) begin
`ifdef LB_ARBITER_RR_EN
            // Tie goes to the master that was not served last.
            gnt_c = last_gnt ? GNT_M0 : GNT_M1;
`else
            gnt_c = GNT_M0;
`endif
        end else if (req[0]) begin
            gnt_c = GNT_M0;
        end else if (req[1]) begin
            gnt_c = GNT_M1;
        end
    end

endmodule

// File: rtl/lb_arbiter.sv
// Two-master LB arbiter: one whole write or read per grant, IDLE between grants.
// Build option LB_ARBITER_RR_EN: round-robin tie-break (fixed priority to M0 otherwise).
module lb_arbiter
    import lb_arbiter_pkg::*;
#(
    parameter  int unsigned ADDR_W = 32,
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_waddr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic              m0_wen,
    output logic              m0_wready,
    input  logic [ADDR_W-1:0] m0_raddr,
    input  logic              m0_ren,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,

    input  logic [ADDR_W-1:0] m1_waddr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic              m1_wen,
    output logic              m1_wready,
    input  logic [ADDR_W-1:0] m1_raddr,
    input  logic              m1_ren,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,

    output logic [ADDR_W-1:0] s_waddr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    output logic              s_wen,
    input  logic              s_wready,
    output logic [ADDR_W-1:0] s_raddr,
    output logic              s_ren,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rvalid,

    output logic [NUM_MASTERS-1:0] gnt
);

    state_e                  state_q, state_d;
    logic [NUM_MASTERS-1:0]  gnt_q, gnt_d;
    logic [NUM_MASTERS-1:0]  req_c, pick_c;
    logic                    win_wen_c, done_c, sel_m1_c;
`ifdef LB_ARBITER_RR_EN
    logic                    last_gnt_q, last_gnt_d;
`endif

    assign req_c     = {m1_wen | m1_ren, m0_wen | m0_ren};
    assign win_wen_c = pick_c[1] ? m1_wen : m0_wen;
    assign sel_m1_c  = gnt_q[1];

    lb_arbiter_picker u_picker (
        .req      (req_c),
`ifdef LB_ARBITER_RR_EN
        .last_gnt (last_gnt_q),
`endif
        .gnt_c    (pick_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_NONE;
`ifdef LB_ARBITER_RR_EN
            last_gnt_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
`ifdef LB_ARBITER_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    // Next state and grant; a write is preferred when the winner asks for both.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_c) begin
                    gnt_d   = pick_c;
                    state_d = win_wen_c ? WR : RD;
                end
            end
            WR:      done_c = s_wen & s_wready;
            RD:      done_c = s_rvalid;
            default: begin
                state_d = IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
        if (done_c) begin
            state_d = IDLE;
            gnt_d   = GNT_NONE;
        end
`ifdef LB_ARBITER_RR_EN
        last_gnt_d = done_c ? sel_m1_c : last_gnt_q;
`endif
    end

    // Data-path muxes; everything is zero outside the granted transaction.
    always_comb begin
        s_wen     = 1'b0;
        s_waddr   = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_ren     = 1'b0;
        s_raddr   = '0;
        m0_wready = 1'b0;
        m1_wready = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        if (state_q == WR) begin
            s_wen     = sel_m1_c ? m1_wen   : m0_wen;
            s_waddr   = sel_m1_c ? m1_waddr : m0_waddr;
            s_wdata   = sel_m1_c ? m1_wdata : m0_wdata;
            s_wstrb   = sel_m1_c ? m1_wstrb : m0_wstrb;
            m0_wready = ~sel_m1_c & s_wready;
            m1_wready = sel_m1_c & s_wready;
        end
        if (state_q == RD) begin
            s_ren   = sel_m1_c ? m1_ren   : m0_ren;
            s_raddr = sel_m1_c ? m1_raddr : m0_raddr;
            if (s_rvalid) begin
                if (sel_m1_c) begin
                    m1_rvalid = 1'b1;
                    m1_rdata  = s_rdata;
                end else begin
                    m0_rvalid = 1'b1;
                    m0_rdata  = s_rdata;
                end
            end
        end
    end

    assign gnt = gnt_q;

endmodule

// File: tb/tb_lb_arbiter.sv
// Directed self-checking bench for lb_arbiter (expectations follow LB_ARBITER_RR_EN).
module tb_lb_arbiter;
    import lb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_waddr, m0_wdata, m0_raddr, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m0_wen, m0_wready, m0_ren, m0_rvalid;
    logic [31:0] m1_waddr, m1_wdata, m1_raddr, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        m1_wen, m1_wready, m1_ren, m1_rvalid;
    logic [31:0] s_waddr, s_wdata, s_raddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_wen, s_wready, s_ren, s_rvalid;
    logic [1:0]  gnt;

    int checks   = 0;
    int failures = 0;

    lb_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wen(m0_wen),
        .m0_wready(m0_wready), .m0_raddr(m0_raddr), .m0_ren(m0_ren),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wen(m1_wen),
        .m1_wready(m1_wready), .m1_raddr(m1_raddr), .m1_ren(m1_ren),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wen(s_wen),
        .s_wready(s_wready), .s_raddr(s_raddr), .s_ren(s_ren),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .gnt(gnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    int order [8];
    int exp_order [8];
    int n, rem0, rem1, good, bad, pulses;
    logic [31:0] first_addr;

    initial begin
        rst = 1'b0;
        {m0_waddr, m0_wdata, m0_wstrb, m0_wen, m0_raddr, m0_ren} = '0;
        {m1_waddr, m1_wdata, m1_wstrb, m1_wen, m1_raddr, m1_ren} = '0;
        {s_wready, s_rdata, s_rvalid} = '0;
`ifdef LB_ARBITER_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif

        // Reset state
        step(); step();
        chk("rst_gnt", gnt, GNT_NONE);
        chk("rst_outs", {s_wen, s_ren, m0_wready, m1_wready, m0_rvalid, m1_rvalid}, 0);
        chk("rst_data", {s_waddr, s_rdata === s_rdata ? m0_rdata : 32'hx}, 0);
        rst = 1'b1;
        step();

        // Contention: both masters keep requesting four writes each
        m0_waddr = 32'h0000_000c; m0_wdata = 32'haaaa_0000; m0_wstrb = 4'hf;
        m1_waddr = 32'h0000_0008; m1_wdata = 32'hbbbb_0000; m1_wstrb = 4'h3;
        s_wready = 1'b1;
        rem0 = 4; rem1 = 4; n = 0; first_addr = '0;
        for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
            m0_wen = (rem0 > 0);
            m1_wen = (rem1 > 0);
            settle();
            if (n == 0 && (m0_wready || m1_wready)) first_addr = s_waddr;
            if (m0_wready && n < 8) begin order[n] = 0; n++; rem0--; end
            if (m1_wready && n < 8) begin order[n] = 1; n++; rem1--; end
            step();
        end
        m0_wen = 1'b0; m1_wen = 1'b0; s_wready = 1'b0;
        chk("cont_count", n, 8);
        chk("cont_first_addr", first_addr, 32'h0000_000c);
        for (int i = 0; i < 8; i++) chk($sformatf("cont_order%0d", i), order[i], exp_order[i]);
        step();

        // M0 write, zero wait states
        m0_waddr = 32'h8000_0004; m0_wdata = 32'hdead_beef; m0_wstrb = 4'hf; m0_wen = 1'b1;
        s_wready = 1'b1;
        step(); settle();
        chk("m0w_swen", s_wen, 1'b1);
        chk("m0w_vals", {s_waddr, s_wdata, s_wstrb}, {32'h8000_0004, 32'hdead_beef, 4'hf});
        chk("m0w_ready", {m0_wready, m1_wready}, 2'b10);
        chk("m0w_gnt", gnt, GNT_M0);
        step(); m0_wen = 1'b0; s_wready = 1'b0; settle();
        chk("m0w_done", {gnt, s_wen, m0_wready}, 0);

        // M1 write with 800 slave wait states
        m1_waddr = 32'h0000_0010; m1_wdata = 32'h00ac_ce55; m1_wstrb = 4'hf; m1_wen = 1'b1;
        step();
        good = 0; pulses = 0;
        for (int i = 0; i < 800; i++) begin
            settle();
            if (s_wen && s_waddr == 32'h10 && s_wdata == 32'h00ac_ce55 && gnt == GNT_M1) good++;
            if (m1_wready || m0_wready) pulses++;
            step();
        end
        chk("m1w_held", good, 800);
        chk("m1w_no_early_ready", pulses, 0);
        s_wready = 1'b1; settle();
        chk("m1w_ready", {m0_wready, m1_wready}, 2'b01);
        step(); m1_wen = 1'b0; s_wready = 1'b0; settle();
        chk("m1w_done", {gnt, s_wen, m1_wready}, 0);

        // M0 read, five wait states
        m0_raddr = 32'h0000_0014; m0_ren = 1'b1;
        step(); settle();
        chk("m0r_sren", {s_ren, s_raddr}, {1'b1, 32'h0000_0014});
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step(); settle();
            if (m0_rvalid || m1_rvalid || m0_rdata != 0 || !s_ren) bad++;
        end
        chk("m0r_wait", bad, 0);
        s_rvalid = 1'b1; s_rdata = 32'hc0de_babe; settle();
        chk("m0r_rvalid", {m0_rvalid, m0_rdata}, {1'b1, 32'hc0de_babe});
        chk("m0r_m1_quiet", {m1_rvalid, m1_rdata}, 0);
        step(); s_rvalid = 1'b0; s_rdata = '0; m0_ren = 1'b0; settle();
        chk("m0r_sren_low", {s_ren, gnt}, 0);

        // M0 read in flight while M1 write arrives
        m0_raddr = 32'h0000_0020; m0_ren = 1'b1;
        step();
        m1_waddr = 32'h0000_0030; m1_wdata = 32'h0000_0011; m1_wen = 1'b1; s_wready = 1'b1;
        settle();
        chk("ovl_wait0", {s_wen, m1_wready, s_ren}, 3'b001);
        step(); settle();
        chk("ovl_wait1", {s_wen, m1_wready, gnt}, {2'b00, GNT_M0});
        s_rvalid = 1'b1; s_rdata = 32'h5555_aaaa; settle();
        chk("ovl_rvalid", {m0_rvalid, s_wen}, 2'b10);
        step(); m0_ren = 1'b0; s_rvalid = 1'b0; s_rdata = '0; settle();
        chk("ovl_idle_gap", {gnt, s_wen, s_ren}, 0);
        step(); settle();
        chk("ovl_m1_wr", {gnt, s_wen, s_waddr, m1_wready}, {GNT_M1, 1'b1, 32'h0000_0030, 1'b1});
        step(); m1_wen = 1'b0; s_wready = 1'b0; settle();
        chk("ovl_done", gnt, GNT_NONE);

        // Reset during a stalled write, M1 write pending
        m0_waddr = 32'h0000_0040; m0_wen = 1'b1;
        step();
        m1_waddr = 32'h0000_0044; m1_wdata = 32'h0000_0044; m1_wen = 1'b1; settle();
        chk("rstw_before", {s_wen, gnt}, {1'b1, GNT_M0});
        rst = 1'b0; settle();
        chk("rstw_abort", {s_wen, s_ren, gnt, m0_wready, m1_wready, s_waddr}, 0);
        m0_wen = 1'b0;
        step(); step();
        rst = 1'b1;
        step(); s_wready = 1'b1; settle();
        chk("rstw_m1_gnt", {gnt, s_wen, s_waddr, m1_wready}, {GNT_M1, 1'b1, 32'h0000_0044, 1'b1});
        step(); m1_wen = 1'b0; s_wready = 1'b0; settle();
        chk("rstw_done", {gnt, s_wen}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lb_arbiter.md
# lb_arbiter

Two-master arbiter for the local bus (LB): it shares one downstream LB register slave between two upstream LB masters, for example an APB-to-LB bridge and a SPI-to-LB bridge. It serves one whole transaction at a time (write or read), with single-cycle arbitration and round-robin or fixed priority. It sits between the bridge outputs and the generated register map.

## Interface
- ADDR_W, 32, LB address width
- DATA_W, 32, LB data width; must be a multiple of 8; STRB_W = DATA_W/8 (localparam)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- mN_waddr / mN_wdata / mN_wstrb  input  ADDR_W / DATA_W / STRB_W  master N write address, data, byte strobes (N = 0, 1)
- mN_wen  input  1  master N write request; held until wready
- mN_wready  output  1  master N write accepted
- mN_raddr  input  ADDR_W  master N read address
- mN_ren  input  1  master N read request; held until rvalid, dropped the cycle after
- mN_rdata  output  DATA_W  master N read data; valid with rvalid, 0 otherwise
- mN_rvalid  output  1  master N read data strobe, one cycle
- s_waddr, s_wdata, s_wstrb, s_wen  output  as above  downstream write channel
- s_wready  input  1  downstream write accept
- s_raddr, s_ren  output  ADDR_W, 1  downstream read channel
- s_rdata, s_rvalid  input  DATA_W, 1  downstream read response
- gnt  output  2  one-hot current grant; 0 when idle

## Operation
- FSM states: IDLE, WR, RD. Grant is held in a register; last_gnt is a 1-bit pointer.
- IDLE: req_N = mN_wen | mN_ren. If any request is set, pick a winner, register gnt and go to WR if the winner's wen is set, otherwise RD. If the winner asserts both wen and ren, write first.
- WR: s_wen/s_waddr/s_wdata/s_wstrb = granted master's signals, combinationally. Granted mN_wready = s_wready. When s_wen & s_wready: update last_gnt, return to IDLE.
- RD: s_ren/s_raddr = granted master's signals. Granted mN_rvalid/mN_rdata = s_rvalid/s_rdata. On s_rvalid: update last_gnt, return to IDLE.
- Non-granted master: wready = 0, rvalid = 0, rdata = 0. Downstream outputs are all 0 in IDLE.
- A granted master that withdraws its request mid-transaction is a protocol violation. The transaction stays open until the slave completes it.
- There is no timeout. Slave wait states of any length are passed through.

## Timing
- Reset (async assert, sync release): state = IDLE, gnt = 0, last_gnt = 1 (port 0 favoured first). All outputs 0.
- Reset asserted mid-transaction aborts it immediately. Downstream wen/ren drop in the same cycle, asynchronously through the state reset.
- Request sampled in IDLE at edge k. s_wen/s_ren are asserted from cycle k+1.
- Write with s_wready = 1: mN_wready high in cycle k+1; IDLE at k+2.
- Read: mN_rvalid is coincident with s_rvalid. Zero slave latency gives rvalid in cycle k+1.
- Minimum of 2 cycles per transaction. IDLE always lasts at least one cycle between grants.
- Simultaneous requests in IDLE go to the arbitration rule (see Configuration). A request arriving during a busy transaction waits and is not lost.

## Configuration
- Macro: LB_ARBITER_RR_EN.
  - Defined: round-robin. On a tie, the winner is the master not equal to last_gnt. last_gnt updates at each completion.
  - Undefined: fixed priority, master 0 always wins ties. last_gnt register is removed.
  - Uncontended behaviour is identical in both modes.

## Structure
- Package lb_arbiter_pkg holds:
  - state enum (IDLE, WR, RD)
  - NUM_MASTERS = 2
  - gnt one-hot constants GNT_NONE / GNT_M0 / GNT_M1
- Sub-module lb_arbiter_picker: combinational winner select from req[1:0] and last_gnt, with the LB_ARBITER_RR_EN variant inside. The top level holds the FSM, grant register and muxes.

## Test plan
- M0 write addr 0x80000004, data 0xdeadbeef, strb 0xF, s_wready = 1 -> s_wen one cycle with those values; m0_wready pulse; m1_wready stays 0.
- M1 write 0x010/0x0acce55 with s_wready held 0 for 800 cycles -> s_wen held 800+ cycles, values stable; single m1_wready pulse when wready rises.
- M0 read 0x014, slave returns 0xc0debabe after 5 wait states -> m0_rvalid one cycle with 0xc0debabe; m1_rdata = 0; s_ren low the next cycle.
- M0 and M1 both write (0x00c, 0x008) in the same cycle, repeated 4 times -> RR: grant order M0, M1, M0, M1…; without macro: M0 served each round, then M1.
- M0 read in flight, M1 write arrives meanwhile -> M1 s_wen only after m0_rvalid, with at least one IDLE cycle between.
- rst asserted while in WR with s_wready = 0 -> s_wen, gnt and all outputs 0 immediately; after release, a pending M1 write is granted normally.
